// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, the instruction-memory request port and the IF/ID
// register, with a one-entry hold buffer for words that return while IF/ID is locked.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_write,
    input  logic          if_id_lock,
    input  logic          if_id_flush,
    input  logic          jump_taken,
    input  logic [15:0]   jump_target,
    fetch_stage_if.master imem,
    output logic [15:0]   if_id_instr,
    output logic [15:0]   if_id_pc,
    output logic          if_id_valid,
    output logic          fetch_busy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] target_reg;
    logic        pending_reg;
    logic [15:0] hold_instr_reg;
    logic [15:0] hold_pc_reg;
    logic [15:0] if_id_instr_reg;
    logic [15:0] if_id_pc_reg;
    logic        if_id_valid_reg;

    logic        req;
    logic        accept;
    logic [15:0] target_aligned;
    logic [15:0] pc_inc;

    assign target_aligned = {jump_target[15:1], 1'b0};
    assign pc_inc         = pc_reg + PC_STEP;

    // PC is frozen while a request is outstanding, so it doubles as the
    // held request address, including the abandoned address in DISCARD.
    always_comb begin
        req = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH:   req = pending_reg || pc_write;
                DISCARD: req = 1'b1;
                default: req = 1'b0;
            endcase
        end
    end

    assign accept = req && imem.imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            target_reg      <= RESET_PC;
            pending_reg     <= 1'b0;
            hold_instr_reg  <= NOP_INSTR;
            hold_pc_reg     <= RESET_PC;
            if_id_instr_reg <= NOP_INSTR;
            if_id_pc_reg    <= RESET_PC;
            if_id_valid_reg <= 1'b0;
        end else begin
            // IF/ID register: flush wins over lock; a jump cycle drops any acked word.
            if (if_id_flush) begin
                if_id_instr_reg <= NOP_INSTR;
                if_id_valid_reg <= 1'b0;
            end else if (!jump_taken && !if_id_lock) begin
                if (state_reg == FETCH && accept) begin
                    if_id_instr_reg <= imem.imem_rdata;
                    if_id_pc_reg    <= pc_reg;
                    if_id_valid_reg <= 1'b1;
                end else if (state_reg == HOLD) begin
                    if_id_instr_reg <= hold_instr_reg;
                    if_id_pc_reg    <= hold_pc_reg;
                    if_id_valid_reg <= 1'b1;
                end
            end

            if (jump_taken) begin
                pending_reg <= 1'b0;
                if (req && !imem.imem_ack) begin
                    target_reg <= target_aligned;
                    state_reg  <= DISCARD;
                end else begin
                    pc_reg    <= target_aligned;
                    state_reg <= FETCH;
                end
            end else begin
                case (state_reg)
                    FETCH: begin
                        pending_reg <= req && !imem.imem_ack;
                        if (accept) begin
                            pc_reg <= pc_inc;
                            if (if_id_lock && !if_id_flush) begin
                                hold_instr_reg <= imem.imem_rdata;
                                hold_pc_reg    <= pc_reg;
                                state_reg      <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (if_id_flush || !if_id_lock) state_reg <= FETCH;
                    end
                    DISCARD: begin
                        if (accept) begin
                            pc_reg    <= target_reg;
                            state_reg <= FETCH;
                        end
                    end
                    default: state_reg <= FETCH;
                endcase
            end
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign if_id_instr    = if_id_instr_reg;
    assign if_id_pc       = if_id_pc_reg;
    assign if_id_valid    = if_id_valid_reg;
    assign fetch_busy     = (req && !imem.imem_ack) || (state_reg == DISCARD);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a scoreboard queue of expected IF/ID words
// is consumed by a monitor, alongside direct checks of the memory port.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        if_id_lock;
    logic        if_id_flush;
    logic        jump_taken;
    logic [15:0] jump_target;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_busy;

    logic        const_en;
    logic        force_ack;
    int          mem_wait;
    int          wait_cnt = 0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_write    (pc_write),
        .if_id_lock  (if_id_lock),
        .if_id_flush (if_id_flush),
        .jump_taken  (jump_taken),
        .jump_target (jump_target),
        .imem        (bus),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .fetch_busy  (fetch_busy)
    );

    always #5 clk = ~clk;

    // Memory model: word = address ^ 3C00 (or constant F050), ack after mem_wait waits.
    assign bus.imem_ack   = (bus.imem_req && (wait_cnt >= mem_wait)) || force_ack;
    assign bus.imem_rdata = const_en ? 16'hF050 : (bus.imem_addr ^ 16'h3C00);

    always @(posedge clk) begin
        if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Monitor: each newly presented valid IF/ID word is popped and compared.
    initial begin
        logic        prev_valid;
        logic [15:0] prev_pc;
        logic [15:0] prev_instr;
        logic [31:0] e;
        prev_valid = 1'b0;
        prev_pc    = 16'h0;
        prev_instr = 16'h0;
        forever begin
            @(negedge clk);
            if (if_id_valid === 1'b1 &&
                (!prev_valid || if_id_pc !== prev_pc || if_id_instr !== prev_instr)) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL ifid_unexpected: got pc=%h instr=%h, expected nothing", if_id_pc, if_id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifid_word", {if_id_pc, if_id_instr}, e);
                end
            end
            prev_valid = (if_id_valid === 1'b1);
            prev_pc    = if_id_pc;
            prev_instr = if_id_instr;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_reset_values();
        chk("rst_instr", {16'h0, if_id_instr}, 32'h0000);
        chk("rst_pc",    {16'h0, if_id_pc},    32'h0000);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
        chk("rst_busy",  {31'h0, fetch_busy},  32'h0);
    endtask

    initial begin
        reset = 1'b1; pc_write = 1'b0; if_id_lock = 1'b0; if_id_flush = 1'b0;
        jump_taken = 1'b0; jump_target = 16'h0; const_en = 1'b1; force_ack = 1'b0;
        mem_wait = 0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk_reset_values();
        tick();

        // Zero-wait streaming of constant F050
        reset = 1'b0; pc_write = 1'b1;
        push(16'h0000, 16'hF050); push(16'h0002, 16'hF050); push(16'h0004, 16'hF050);
        @(negedge clk);
        chk("t1_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t1_addr", {16'h0, bus.imem_addr}, 32'h0000);
        tick(); tick(); tick();
        pc_write = 1'b0;
        @(negedge clk);
        chk("t1_req_stop", {31'h0, bus.imem_req}, 32'h0);
        chk("t1_busy", {31'h0, fetch_busy}, 32'h0);
        tick();

        // Jump (bit 0 forced low) to FC00, whose word is C000; then lock for 3 cycles
        jump_taken = 1'b1; jump_target = 16'hFC01; if_id_flush = 1'b1;
        tick();
        jump_taken = 1'b0; if_id_flush = 1'b0; const_en = 1'b0; pc_write = 1'b1;
        push(16'hFC00, 16'hC000);
        @(negedge clk);
        chk("t2_addr", {16'h0, bus.imem_addr}, 32'hFC00);
        tick();
        if_id_lock = 1'b1; pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_locked_instr", {16'h0, if_id_instr}, 32'hC000);
            chk("t2_locked_req", {31'h0, bus.imem_req}, 32'h0);
            tick();
        end
        if_id_lock = 1'b0; pc_write = 1'b1;
        push(16'hFC02, 16'hC002); push(16'hFC04, 16'hC004);
        @(negedge clk);
        chk("t2_resume_addr", {16'h0, bus.imem_addr}, 32'hFC02);
        tick(); tick();

        // Ack while locked goes through the hold buffer exactly once
        if_id_lock = 1'b1;
        push(16'hFC06, 16'hC006);
        @(negedge clk);
        chk("t4_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t4_addr", {16'h0, bus.imem_addr}, 32'hFC06);
        tick();
        @(negedge clk);
        chk("t4_hold_req", {31'h0, bus.imem_req}, 32'h0);
        chk("t4_hold_pc", {16'h0, if_id_pc}, 32'hFC04);
        tick();
        if_id_lock = 1'b0; pc_write = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_out_pc", {16'h0, if_id_pc}, 32'hFC06);
        chk("t4_out_instr", {16'h0, if_id_instr}, 32'hC006);
        tick();

        // Flush with lock while the hold buffer is full
        pc_write = 1'b1; if_id_lock = 1'b1;
        tick();
        if_id_flush = 1'b1; pc_write = 1'b0;
        tick();
        if_id_flush = 1'b0; if_id_lock = 1'b0;
        @(negedge clk);
        chk("t5_instr", {16'h0, if_id_instr}, 32'h0000);
        chk("t5_valid", {31'h0, if_id_valid}, 32'h0);
        tick();
        @(negedge clk);
        chk("t5_hold_dropped", {31'h0, if_id_valid}, 32'h0);
        tick();
        pc_write = 1'b1;
        push(16'hFC0A, 16'hC00A);
        @(negedge clk);
        chk("t5_no_rewind", {16'h0, bus.imem_addr}, 32'hFC0A);
        tick();

        // 3-wait memory, jump to 0040 during the wait
        mem_wait = 3;
        @(negedge clk);
        chk("t3_busy", {31'h0, fetch_busy}, 32'h1);
        chk("t3_addr", {16'h0, bus.imem_addr}, 32'hFC0C);
        tick();
        pc_write = 1'b0;
        @(negedge clk);
        chk("t3_req_held", {31'h0, bus.imem_req}, 32'h1);
        chk("t3_addr_held", {16'h0, bus.imem_addr}, 32'hFC0C);
        tick();
        jump_taken = 1'b1; jump_target = 16'h0040; if_id_flush = 1'b1;
        tick();
        jump_taken = 1'b0; if_id_flush = 1'b0;
        @(negedge clk);
        chk("t3_discard_req", {31'h0, bus.imem_req}, 32'h1);
        chk("t3_discard_addr", {16'h0, bus.imem_addr}, 32'hFC0C);
        chk("t3_discard_busy", {31'h0, fetch_busy}, 32'h1);
        tick();
        mem_wait = 0; pc_write = 1'b1;
        push(16'h0040, 16'h3C40);
        @(negedge clk);
        chk("t3_target_addr", {16'h0, bus.imem_addr}, 32'h0040);
        tick();
        pc_write = 1'b0;
        @(negedge clk);
        chk("t3_ifid_pc", {16'h0, if_id_pc}, 32'h0040);
        tick();

        // PC wrap-around from FFFE
        jump_taken = 1'b1; jump_target = 16'hFFFE; if_id_flush = 1'b1;
        tick();
        jump_taken = 1'b0; if_id_flush = 1'b0; pc_write = 1'b1;
        push(16'hFFFE, 16'hC3FE); push(16'h0000, 16'h3C00);
        @(negedge clk);
        chk("t7_addr_fffe", {16'h0, bus.imem_addr}, 32'hFFFE);
        tick();
        @(negedge clk);
        chk("t7_addr_wrap", {16'h0, bus.imem_addr}, 32'h0000);
        tick();

        // Reset while a request is outstanding and ack arrives in the reset cycle
        mem_wait = 3;
        tick();
        reset = 1'b1; force_ack = 1'b1; pc_write = 1'b0;
        tick();
        reset = 1'b0; force_ack = 1'b0; mem_wait = 0;
        @(negedge clk);
        chk_reset_values();
        tick();
        pc_write = 1'b1;
        push(16'h0000, 16'h3C00);
        @(negedge clk);
        chk("t6_restart_addr", {16'h0, bus.imem_addr}, 32'h0000);
        tick();
        pc_write = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
